// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared bus definitions for the tagged memory responder.
//               Holds the bus command encoding, tag constants, the
//               return-pipe entry layout, and a lowest-free-tag helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  localparam int         NUM_MEM_TAGS = 15;
  localparam logic [3:0] MEM_TAG_NONE = 4'd0;

  typedef struct packed {
    logic        valid;
    logic [3:0]  tag;
    logic [63:0] data;
  } MEM_RET_ENTRY;

  // Bit i of the free list stands for tag i+1; scanning downwards leaves
  // the lowest set bit as the final answer.
  function automatic logic [3:0] lowest_free_tag(input logic [NUM_MEM_TAGS-1:0] free_list);
    lowest_free_tag = MEM_TAG_NONE;
    for (int i = NUM_MEM_TAGS - 1; i >= 0; i--) begin
      if (free_list[i]) lowest_free_tag = 4'(i + 1);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : mem_tag_allocator
// Description : Free list for memory tags 1..15 with a lowest-free priority
//               encoder. A grant marks its tag busy on the clock edge; a
//               release marks its tag free on the clock edge.
// Ports       : clock, reset      - clock, async active-high reset
//               i_grant_en        - consume o_grant_tag this cycle
//               o_grant_tag       - lowest free tag (0 when none free)
//               o_any_free        - at least one tag free
//               i_release_en/tag  - return a tag to the free list
// Revision    : 1.0 - initial release
// ============================================================================
module mem_tag_allocator
  import mem_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_grant_en,
  output logic [3:0] o_grant_tag,
  output logic       o_any_free,
  input  logic       i_release_en,
  input  logic [3:0] i_release_tag
);

  logic [NUM_MEM_TAGS-1:0] r_free_list;
  logic [NUM_MEM_TAGS-1:0] w_grant_mask;
  logic [NUM_MEM_TAGS-1:0] w_release_mask;

  assign o_grant_tag = lowest_free_tag(r_free_list);
  assign o_any_free  = |r_free_list;

  // One-hot masks per tag; a tag being released is busy, so it can never be
  // the one granted in the same cycle.
  for (genvar gi = 0; gi < NUM_MEM_TAGS; gi++) begin : g_mask
    assign w_grant_mask[gi]   = i_grant_en   && (o_grant_tag   == 4'(gi + 1));
    assign w_release_mask[gi] = i_release_en && (i_release_tag == 4'(gi + 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_free_list <= '1;
    end else begin
      r_free_list <= (r_free_list & ~w_grant_mask) | w_release_mask;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Tagged main-memory responder. Accepts one load/store per
//               cycle, grants a tag in the same cycle and returns the tagged
//               load data (or a zero-data store completion) LATENCY cycles
//               after the response cycle.
// Ports       : clock, reset        - clock, async active-high reset
//               proc2mem_command    - BUS_NONE / BUS_LOAD / BUS_STORE
//               proc2mem_addr       - byte address, doubleword aligned
//               proc2mem_data       - store data
//               mem2proc_response   - granted tag this cycle (0 = refused)
//               mem2proc_data       - returned doubleword (0 when no tag)
//               mem2proc_tag        - tag whose data is valid (0 = none)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_DW = 8192,
  parameter int LATENCY      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  BUS_COMMAND      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam int C_ADDR_W = $clog2(MEM_DEPTH_DW);

  logic [63:0]      r_mem [MEM_DEPTH_DW];
  MEM_RET_ENTRY     r_pipe [LATENCY];

  logic [XLEN-4:0]  w_dw_index;
  logic [C_ADDR_W-1:0] w_mem_addr;
  logic             w_in_range;
  logic             w_is_store;
  logic             w_accept;
  logic [3:0]       w_grant_tag;
  logic             w_any_free;
  logic [63:0]      w_push_data;
  logic [2:0]       w_unused_addr_bits;

  assign w_dw_index         = proc2mem_addr[XLEN-1:3];
  assign w_mem_addr         = w_dw_index[C_ADDR_W-1:0];
  assign w_unused_addr_bits = proc2mem_addr[2:0];
  assign w_in_range         = (32'(w_dw_index) < 32'(MEM_DEPTH_DW));
  assign w_is_store         = (proc2mem_command == BUS_STORE);

  // Gating with reset keeps the response at 0 while reset is held, even
  // though the free list reads all-free during that time.
  assign w_accept = !reset && (proc2mem_command != BUS_NONE) && w_in_range && w_any_free;

  mem_tag_allocator u_alloc (
    .clock         (clock),
    .reset         (reset),
    .i_grant_en    (w_accept),
    .o_grant_tag   (w_grant_tag),
    .o_any_free    (w_any_free),
    .i_release_en  (r_pipe[LATENCY-1].valid),
    .i_release_tag (r_pipe[LATENCY-1].tag)
  );

  assign mem2proc_response = w_accept ? w_grant_tag : MEM_TAG_NONE;

  // The load value is captured into the pipe at the accept edge, so later
  // stores to the same doubleword cannot change what is returned.
  assign w_push_data = (w_accept && !w_is_store) ? r_mem[w_mem_addr] : 64'h0;

  // Backing array has no reset; its contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_store) begin
      r_mem[w_mem_addr] <= proc2mem_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_accept, tag: w_grant_tag, data: w_push_data};
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign mem2proc_tag  = r_pipe[LATENCY-1].valid ? r_pipe[LATENCY-1].tag  : MEM_TAG_NONE;
  assign mem2proc_data = r_pipe[LATENCY-1].valid ? r_pipe[LATENCY-1].data : 64'h0;

endmodule
`default_nettype wire
